// File: rtl/alu_cc_writeback.sv
// Execute-stage back end: holds the integer condition codes, feeds carry back to the ALU,
// and queues ALU results toward register-file writeback.
module alu_cc_writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_n,
    input  logic              in_z,
    input  logic              in_c,
    input  logic              in_v,
    input  logic [5:0]        in_opcode,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wr_en,
    input  logic              flush,
    input  logic              icc_wr_en,
    input  logic [3:0]        icc_wr_data,
    output logic [3:0]        icc,
    output logic              carry_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wr_en
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              wr_en;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             pop;
    entry_t           head;

    // Only the S bit of the opcode matters here.
    logic unused_opcode;
    assign unused_opcode = ^{in_opcode[5], in_opcode[3:0]};

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    assign head       = mem[rd_ptr];
    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_wr_en  = head.wr_en;
    assign carry_out  = icc[1];

    // Queue storage; writes to r0 are squashed at entry time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wr_ptr] <= '{result: in_result,
                             rd:     in_rd,
                             wr_en:  in_wr_en & (in_rd != '0)};
        end
    end

    // Pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept && !pop)      count <= count + CNT_W'(1);
            else if (!accept && pop) count <= count - CNT_W'(1);
        end
    end

    // Condition codes update at accept time, explicit load has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icc <= 4'b0000;
        end else if (icc_wr_en) begin
            icc <= icc_wr_data;
        end else if (accept && in_opcode[4]) begin
            icc <= {in_n, in_z, in_c, in_v};
        end
    end

endmodule

// File: tb/tb_alu_cc_writeback.sv
// Bench for alu_cc_writeback: vector table plus directed corner sequences,
// with a per-cycle scoreboard model of the queue and condition codes.
module tb_alu_cc_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_n, in_z, in_c, in_v;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rd;
    logic        in_wr_en;
    logic        flush;
    logic        icc_wr_en;
    logic [3:0]  icc_wr_data;
    logic [3:0]  icc;
    logic        carry_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wr_en;

    alu_cc_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_wr_en(in_wr_en),
        .flush(flush), .icc_wr_en(icc_wr_en), .icc_wr_data(icc_wr_data),
        .icc(icc), .carry_out(carry_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr_en;
    } exp_t;

    localparam int DEPTH = 2;
    exp_t       exp_q[$];
    exp_t       e;
    logic [3:0] icc_m = 4'b0000;
    bit         m_acc, m_pop;

    // Scoreboard: inputs/outputs seen at negedge are what the next posedge acts on.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            icc_m = 4'b0000;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_icc", 64'(icc), 64'd0);
        end else begin
            chk("sb_in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            chk("sb_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("sb_icc", 64'(icc), 64'(icc_m));
            chk("sb_carry_out", 64'(carry_out), 64'(icc_m[1]));
            if (exp_q.size() != 0) begin
                chk("sb_out_result", 64'(out_result), 64'(exp_q[0].result));
                chk("sb_out_rd", 64'(out_rd), 64'(exp_q[0].rd));
                chk("sb_out_wr_en", 64'(out_wr_en), 64'(exp_q[0].wr_en));
            end
            m_acc = in_valid && (exp_q.size() < DEPTH) && !flush;
            m_pop = (exp_q.size() != 0) && out_ready;
            if (icc_wr_en)                  icc_m = icc_wr_data;
            else if (m_acc && in_opcode[4]) icc_m = {in_n, in_z, in_c, in_v};
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_acc) begin
                    e.result = in_result;
                    e.rd     = in_rd;
                    e.wr_en  = in_wr_en && (in_rd != 5'd0);
                    exp_q.push_back(e);
                end
            end
        end
    end

    typedef struct {
        logic [5:0]  opcode;
        logic [31:0] result;
        logic [3:0]  nzcv;
        logic [4:0]  rd;
        logic        wr_en;
        logic [3:0]  exp_icc;
        logic        exp_wr;
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] res, input logic [3:0] f,
                         input logic [4:0] rd, input logic wr);
        in_valid  = 1'b1;
        in_opcode = op;
        in_result = res;
        {in_n, in_z, in_c, in_v} = f;
        in_rd     = rd;
        in_wr_en  = wr;
    endtask

    int got[$];
    bit will_acc;

    initial begin
        vt[0] = '{6'b010000, 32'h0000_0000, 4'b0110, 5'd3,  1'b1, 4'b0110, 1'b1};
        vt[1] = '{6'b000001, 32'h0000_0000, 4'b1000, 5'd4,  1'b1, 4'b0110, 1'b1};
        vt[2] = '{6'b010010, 32'hFFFF_FFFF, 4'b1000, 5'd0,  1'b1, 4'b1000, 1'b0};
        vt[3] = '{6'b010000, 32'h0000_0005, 4'b0001, 5'd31, 1'b0, 4'b0001, 1'b0};
        vt[4] = '{6'b000000, 32'h0000_0007, 4'b1111, 5'd7,  1'b1, 4'b0001, 1'b1};
        vt[5] = '{6'b110000, 32'h0000_0008, 4'b0010, 5'd1,  1'b1, 4'b0010, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; {in_n, in_z, in_c, in_v} = 4'b0;
        in_opcode = '0; in_rd = '0; in_wr_en = 1'b0; flush = 1'b0;
        icc_wr_en = 1'b0; icc_wr_data = '0; out_ready = 1'b1;
        tick(); tick();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", 64'(out_result), 64'd0);
        chk("reset_out_rd", 64'(out_rd), 64'd0);
        chk("reset_out_wr_en", 64'(out_wr_en), 64'd0);
        chk("reset_icc", 64'(icc), 64'd0);
        chk("reset_carry", 64'(carry_out), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back ops with continuous drain: each result is at the head one cycle later.
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].opcode, vt[i].result, vt[i].nzcv, vt[i].rd, vt[i].wr_en);
            tick();
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_out_result", i), 64'(out_result), 64'(vt[i].result));
            chk($sformatf("vec%0d_out_rd", i), 64'(out_rd), 64'(vt[i].rd));
            chk($sformatf("vec%0d_out_wr_en", i), 64'(out_wr_en), 64'(vt[i].exp_wr));
            chk($sformatf("vec%0d_icc", i), 64'(icc), 64'(vt[i].exp_icc));
            chk($sformatf("vec%0d_carry", i), 64'(carry_out), 64'(vt[i].exp_icc[1]));
        end
        in_valid = 1'b0;
        tick();
        chk("drained_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: fill the queue, hold the head, then drain in order.
        out_ready = 1'b0;
        drive(6'b000000, 32'd1, 4'b0000, 5'd9, 1'b1); tick();
        drive(6'b000000, 32'd2, 4'b0000, 5'd9, 1'b1); tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(6'b000000, 32'd3, 4'b0000, 5'd9, 1'b1); tick();
        chk("full_in_ready_hold", 64'(in_ready), 64'd0);
        chk("full_head_held", 64'(out_result), 64'd1);
        tick();
        chk("full_head_still_held", 64'(out_result), 64'd1);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) got.push_back(int'(out_result));
            will_acc = in_valid && in_ready;
            tick();
            if (will_acc) in_valid = 1'b0;
        end
        chk("drain_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk($sformatf("drain_order%0d", i), 64'(got[i]), 64'(i + 1));
            else                chk($sformatf("drain_order%0d", i), 64'hDEAD, 64'(i + 1));
        end
        chk("drain_in_ready", 64'(in_ready), 64'd1);

        // Flush discards queued entries and the same-cycle S-op.
        out_ready = 1'b0;
        drive(6'b000000, 32'hA, 4'b0000, 5'd2, 1'b1); tick();
        drive(6'b000000, 32'hB, 4'b0000, 5'd2, 1'b1); tick();
        drive(6'b010000, 32'hC, 4'b1000, 5'd2, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_icc", 64'(icc), 64'b0010);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        drive(6'b000000, 32'h1234_5678, 4'b0000, 5'd6, 1'b1); tick();
        in_valid = 1'b0;
        chk("post_flush_out_result", 64'(out_result), 64'h1234_5678);
        out_ready = 1'b1;
        tick();

        // Explicit icc load beats a same-cycle S-op, and still works during flush.
        drive(6'b010000, 32'h0, 4'b0100, 5'd5, 1'b1);
        icc_wr_en = 1'b1; icc_wr_data = 4'b1111;
        tick();
        in_valid = 1'b0;
        chk("iccwr_icc", 64'(icc), 64'b1111);
        chk("iccwr_carry", 64'(carry_out), 64'd1);
        flush = 1'b1; icc_wr_data = 4'b0101;
        tick();
        flush = 1'b0; icc_wr_en = 1'b0;
        chk("iccwr_flush_icc", 64'(icc), 64'b0101);
        chk("iccwr_flush_carry", 64'(carry_out), 64'd0);

        // Asynchronous reset with two entries queued.
        out_ready = 1'b0;
        drive(6'b010000, 32'h11, 4'b0010, 5'd8, 1'b1); tick();
        drive(6'b000000, 32'h22, 4'b0000, 5'd8, 1'b1); tick();
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_icc", 64'(icc), 64'd0);
        chk("midrst_carry", 64'(carry_out), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid_after", 64'(out_valid), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
